// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, baud-rate
// selection encodings and timeout defaults.
package uart_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      BUSY = 2'b10,
      CFG  = 2'b11
   } state_e;

   // Baud-rate generator selection codes.
   typedef enum logic [1:0] {
      BRG_9600  = 2'b00,
      BRG_19200 = 2'b01,
      BRG_38400 = 2'b10,
      BRG_57600 = 2'b11
   } brg_sel_e;

   // Default frame timeout, in BUSY cycles, and the width of its counter.
   localparam int TIMEOUT_CYCLES_DEF = 4096;
   localparam int TMO_CNT_W          = 12;

endpackage : uart_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit,
// starting one position above the last winner and wrapping around.
module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic                       grant_vld,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int IW = $clog2(NUM_REQ);

   logic [IW-1:0]      start;
   logic [NUM_REQ-1:0] rot;
   logic [IW-1:0]      pos;

   // Rotate the request vector so the search start sits at bit 0, then take
   // the lowest set bit. NUM_REQ is a power of two, so index arithmetic in
   // IW bits wraps modulo NUM_REQ for free.
   always_comb begin
      // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
      start = last + IW'(1);
      rot   = NUM_REQ'({req, req} >> start);
      pos   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) pos = IW'(i);
      end
      grant_vld = |req;
      grant_idx = start + pos;
   end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Also sequences baud-rate changes so they only take effect between frames,
// and abandons a frame whose tx_done never arrives.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                            clk_576KHz,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            tx_valid,
   output logic [DATA_WIDTH-1:0]           tx_data,
   input  logic                            tx_ready,
   input  logic                            tx_done,
   input  logic [1:0]                      brg_select_req,
   input  logic                            brg_update,
   output logic [1:0]                      brg_select,
   output logic                            timeout_err
);

   localparam int                 IW       = $clog2(NUM_REQ);
   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                 state_q,       state_d;
   logic [IW-1:0]          last_grant_q,  last_grant_d;
   logic [IW-1:0]          grant_id_q,    grant_id_d;
   logic [NUM_REQ-1:0]     req_ready_q,   req_ready_d;
   logic [DATA_WIDTH-1:0]  data_q,        data_d;
   logic [1:0]             brg_select_q,  brg_select_d;
   logic [1:0]             brg_capt_q,    brg_capt_d;
   logic                   cfg_pending_q, cfg_pending_d;
   logic [TMO_CNT_W-1:0]   tmo_cnt_q,     tmo_cnt_d;
   logic                   tmo_err_q,     tmo_err_d;

   logic                   pick_vld;
   logic [IW-1:0]          pick_idx;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req       (req_valid),
      .last      (last_grant_q),
      .grant_vld (pick_vld),
      .grant_idx (pick_idx)
   );

   // State register and all datapath registers, cleared asynchronously.
   always_ff @(posedge clk_576KHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_grant_q  <= IW'(NUM_REQ - 1);
         grant_id_q    <= '0;
         req_ready_q   <= '0;
         data_q        <= '0;
         brg_select_q  <= BRG_9600;
         brg_capt_q    <= BRG_9600;
         cfg_pending_q <= 1'b0;
         tmo_cnt_q     <= '0;
         tmo_err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_id_q    <= grant_id_d;
         req_ready_q   <= req_ready_d;
         data_q        <= data_d;
         brg_select_q  <= brg_select_d;
         brg_capt_q    <= brg_capt_d;
         cfg_pending_q <= cfg_pending_d;
         tmo_cnt_q     <= tmo_cnt_d;
         tmo_err_q     <= tmo_err_d;
      end
   end

   // Next-state and next-register logic; pulses default low each cycle.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_id_d    = grant_id_q;
      req_ready_d   = '0;
      data_d        = data_q;
      brg_select_d  = brg_select_q;
      brg_capt_d    = brg_capt_q;
      cfg_pending_d = cfg_pending_q;
      tmo_cnt_d     = tmo_cnt_q;
      tmo_err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A pending baud change is applied before any new frame starts.
            if (cfg_pending_q) begin
               state_d = CFG;
            end else if (pick_vld && tx_ready) begin
               grant_id_d  = pick_idx;
               data_d      = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
               req_ready_d = NUM_REQ'(1) << pick_idx;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            // Priority rotates only once the transmitter has taken the character.
            if (tx_ready) begin
               state_d      = BUSY;
               last_grant_d = grant_id_q;
               tmo_cnt_d    = '0;
            end
         end
         BUSY: begin
            // tx_done beats a timeout landing in the same cycle.
            if (tx_done) begin
               state_d = IDLE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d   = IDLE;
               tmo_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
            end
         end
         CFG: begin
            brg_select_d  = brg_capt_q;
            cfg_pending_d = 1'b0;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A baud request is captured in any state; it overrides the CFG clear
      // so an update arriving during CFG is kept for the next pass.
      if (brg_update) begin
         brg_capt_d    = brg_select_req;
         cfg_pending_d = 1'b1;
      end
   end

   assign req_ready   = req_ready_q;
   assign grant_id    = grant_id_q;
   assign tx_valid    = (state_q == LOAD);
   assign tx_data     = data_q;
   assign brg_select  = brg_select_q;
   assign timeout_err = tmo_err_q;

endmodule : uart_tx_arbiter
